pbkdf2_n_ct: RTL and testbench

PBKDF2_N_CT -- requirements
Module: pbkdf2_n_ct

---
 rtl/pbkdf2_pkg.sv | 19 +
 rtl/pbkdf2_n_ct.sv | 157 +++++++++++++++
 tb/tb_pbkdf2_n_ct.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pbkdf2_pkg.sv
// Shared definitions for the PBKDF2 controller and its datapath:
// controller state encodings and chaining-value select codes.
package pbkdf2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STORE_IO = 3'd1,
        ST_IHASH    = 3'd2,
        ST_ISTORE   = 3'd3,
        ST_OHASH    = 3'd4,
        ST_OSTORE   = 3'd5,
        ST_DONE     = 3'd6
    } pbkdf2_state_e;

    localparam logic [1:0] SEL_IXOR = 2'd0;
    localparam logic [1:0] SEL_MEM0 = 2'd1;
    localparam logic [1:0] SEL_OXOR = 2'd2;

endpackage

// File: rtl/pbkdf2_n_ct.sv
// PBKDF2 control FSM: sequences N_IBLK inner-hash blocks plus one outer hash
// per derived block, for N_OUT derived blocks, steering an external SHA-256 core.
module pbkdf2_n_ct
    import pbkdf2_pkg::*;
#(
    parameter int N_IBLK = 3,
    parameter int N_OUT  = 1,
    localparam int IW    = (N_IBLK > 1) ? $clog2(N_IBLK) : 1,
    localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          init,
    input  logic          abort,
    input  logic          sha256_digest_valid,
    output logic          sha256_init,
    output logic [1:0]    sel_prev_hash,
    output logic          sel_outer,
    output logic [IW-1:0] blk_idx,
    output logic [OW-1:0] out_idx,
    output logic          store_i_o_hash,
    output logic          update_mem_0,
    output logic          store_out,
    output logic          busy,
    output logic          valid
);

    localparam logic [IW-1:0] BLK_LAST = IW'(N_IBLK - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(N_OUT - 1);

    pbkdf2_state_e   state_q, state_d;
    logic [IW-1:0]   blk_cnt_q, blk_cnt_d;
    logic [OW-1:0]   out_cnt_q, out_cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            blk_cnt_q <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            blk_cnt_q <= blk_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        blk_cnt_d = blk_cnt_q;
        out_cnt_d = out_cnt_q;
        if (abort) begin
            state_d   = ST_IDLE;
            blk_cnt_d = '0;
            out_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (init) begin
                        state_d   = ST_STORE_IO;
                        blk_cnt_d = '0;
                        out_cnt_d = '0;
                    end
                end
                ST_STORE_IO: state_d = ST_IHASH;
                ST_IHASH: begin
                    if (sha256_digest_valid) state_d = ST_ISTORE;
                end
                ST_ISTORE: begin
                    if (blk_cnt_q == BLK_LAST) begin
                        blk_cnt_d = '0;
                        state_d   = ST_OHASH;
                    end else begin
                        blk_cnt_d = blk_cnt_q + IW'(1);
                        state_d   = ST_IHASH;
                    end
                end
                ST_OHASH: begin
                    if (sha256_digest_valid) state_d = ST_OSTORE;
                end
                ST_OSTORE: begin
                    if (out_cnt_q == OUT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        out_cnt_d = out_cnt_q + OW'(1);
                        blk_cnt_d = '0;
                        state_d   = ST_IHASH;
                    end
                end
                ST_DONE: begin
                    if (!init) state_d = ST_IDLE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    blk_cnt_d = '0;
                    out_cnt_d = '0;
                end
            endcase
        end
    end

    // Store states already present the following hash's mux selection so the
    // datapath has a full cycle to settle before the SHA core starts.
    always_comb begin
        sha256_init    = 1'b0;
        sel_prev_hash  = SEL_IXOR;
        sel_outer      = 1'b0;
        blk_idx        = '0;
        out_idx        = '0;
        store_i_o_hash = 1'b0;
        update_mem_0   = 1'b0;
        store_out      = 1'b0;
        busy           = 1'b0;
        valid          = 1'b0;
        case (state_q)
            ST_STORE_IO: begin
                store_i_o_hash = 1'b1;
                busy           = 1'b1;
            end
            ST_IHASH: begin
                sha256_init   = 1'b1;
                sel_prev_hash = (blk_cnt_q == '0) ? SEL_IXOR : SEL_MEM0;
                blk_idx       = blk_cnt_q;
                out_idx       = out_cnt_q;
                busy          = 1'b1;
            end
            ST_ISTORE: begin
                update_mem_0 = 1'b1;
                blk_idx      = blk_cnt_q;
                out_idx      = out_cnt_q;
                busy         = 1'b1;
                if (blk_cnt_q == BLK_LAST) begin
                    sel_prev_hash = SEL_OXOR;
                    sel_outer     = 1'b1;
                end else begin
                    sel_prev_hash = SEL_MEM0;
                end
            end
            ST_OHASH: begin
                sha256_init   = 1'b1;
                sel_prev_hash = SEL_OXOR;
                sel_outer     = 1'b1;
                blk_idx       = blk_cnt_q;
                out_idx       = out_cnt_q;
                busy          = 1'b1;
            end
            ST_OSTORE: begin
                store_out = 1'b1;
                blk_idx   = blk_cnt_q;
                out_idx   = out_cnt_q;
                busy      = 1'b1;
            end
            ST_DONE: valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pbkdf2_n_ct.sv
// Self-checking bench for pbkdf2_n_ct: three parameterisations driven from
// cycle-accurate expected traces generated from the block's schedule.
module tb_pbkdf2_n_ct;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic init_v [3];
    logic abort_v[3];
    logic dv_v   [3];

    int niblk_t[3] = '{3, 2, 1};
    int nout_t [3] = '{1, 4, 1};

    logic       sha0, so0, sio0, upd0, sto0, busy0, vld0;
    logic [1:0] sp0;
    logic [1:0] bi0;
    logic [0:0] oi0;
    logic       sha1, so1, sio1, upd1, sto1, busy1, vld1;
    logic [1:0] sp1;
    logic [0:0] bi1;
    logic [1:0] oi1;
    logic       sha2, so2, sio2, upd2, sto2, busy2, vld2;
    logic [1:0] sp2;
    logic [0:0] bi2;
    logic [0:0] oi2;

    // Observation word: {sha, sel_prev[1:0], sel_outer, blk[3:0], out[3:0], sio, upd, sto, busy, valid}
    logic [16:0] obs[3];
    assign obs[0] = {sha0, sp0, so0, 4'(bi0), 4'(oi0), sio0, upd0, sto0, busy0, vld0};
    assign obs[1] = {sha1, sp1, so1, 4'(bi1), 4'(oi1), sio1, upd1, sto1, busy1, vld1};
    assign obs[2] = {sha2, sp2, so2, 4'(bi2), 4'(oi2), sio2, upd2, sto2, busy2, vld2};

    pbkdf2_n_ct #(.N_IBLK(3), .N_OUT(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .init(init_v[0]), .abort(abort_v[0]),
        .sha256_digest_valid(dv_v[0]), .sha256_init(sha0), .sel_prev_hash(sp0),
        .sel_outer(so0), .blk_idx(bi0), .out_idx(oi0), .store_i_o_hash(sio0),
        .update_mem_0(upd0), .store_out(sto0), .busy(busy0), .valid(vld0));

    pbkdf2_n_ct #(.N_IBLK(2), .N_OUT(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .init(init_v[1]), .abort(abort_v[1]),
        .sha256_digest_valid(dv_v[1]), .sha256_init(sha1), .sel_prev_hash(sp1),
        .sel_outer(so1), .blk_idx(bi1), .out_idx(oi1), .store_i_o_hash(sio1),
        .update_mem_0(upd1), .store_out(sto1), .busy(busy1), .valid(vld1));

    pbkdf2_n_ct #(.N_IBLK(1), .N_OUT(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .init(init_v[2]), .abort(abort_v[2]),
        .sha256_digest_valid(dv_v[2]), .sha256_init(sha2), .sel_prev_hash(sp2),
        .sel_outer(so2), .blk_idx(bi2), .out_idx(oi2), .store_i_o_hash(sio2),
        .update_mem_0(upd2), .store_out(sto2), .busy(busy2), .valid(vld2));

    typedef struct {
        logic [16:0] obs;
        bit          dv;
        bit          init;
    } step_t;

    typedef struct {
        int inst;
        int k;
        bit spur;
        int hold;
        int exp_lat;
        int exp_mem0;
        int exp_so;
    } vec_t;

    step_t trace[$];
    int    abort_idx;
    int    ohash_idx;
    int    n_pass  = 0;
    int    n_checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input int inst, input logic ini, input logic abt, input logic dv);
        init_v[inst]  = ini;
        abort_v[inst] = abt;
        dv_v[inst]    = dv;
    endtask

    function automatic logic [16:0] mk(bit sha, logic [1:0] sp, bit so, int blk, int oi,
                                       bit sio, bit upd, bit sto, bit bsy, bit vld);
        return {sha, sp, so, 4'(blk), 4'(oi), sio, upd, sto, bsy, vld};
    endfunction

    function automatic void push(logic [16:0] o, bit dv, bit ini);
        step_t s;
        s.obs  = o;
        s.dv   = dv;
        s.init = ini;
        trace.push_back(s);
    endfunction

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected per-cycle behaviour of one complete operation, starting with the
    // cycle after init is sampled. dv fires on the k-th cycle of every hash.
    function automatic void build_trace(int inst, int kfix, bit spur, int hold);
        int ni = niblk_t[inst];
        int no = nout_t[inst];
        int k;
        trace.delete();
        abort_idx = -1;
        ohash_idx = -1;
        push(mk(0, 2'd0, 0, 0, 0, 1, 0, 0, 1, 0), spur | rbit(), rbit());
        for (int o = 0; o < no; o++) begin
            for (int b = 0; b < ni; b++) begin
                k = (kfix > 0) ? kfix : $urandom_range(1, 6);
                for (int c = 1; c <= k; c++) begin
                    if (o == 1 && b == 1 && c == 1) abort_idx = trace.size();
                    push(mk(1, (b == 0) ? 2'd0 : 2'd1, 0, b, o, 0, 0, 0, 1, 0), c == k, rbit());
                end
                if (b == ni - 1) push(mk(0, 2'd2, 1, b, o, 0, 1, 0, 1, 0), spur | rbit(), rbit());
                else             push(mk(0, 2'd1, 0, b, o, 0, 1, 0, 1, 0), spur | rbit(), rbit());
            end
            k = (kfix > 0) ? kfix : $urandom_range(1, 6);
            for (int c = 1; c <= k; c++) begin
                if (o == 0 && c == 1) ohash_idx = trace.size();
                push(mk(1, 2'd2, 1, 0, o, 0, 0, 0, 1, 0), c == k, rbit());
            end
            push(mk(0, 2'd0, 0, 0, o, 0, 0, 1, 1, 0), spur | rbit(), rbit());
        end
        for (int h = 0; h < hold; h++) push(mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1), spur | rbit(), 1'b1);
        push(mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1), spur | rbit(), 1'b0);
        push(17'd0, rbit(), 1'b0);
    endfunction

    // mode 0 = full run, 1 = abort in second IHASH of out_idx 1, 2 = reset mid-OHASH
    task automatic run_op(input int inst, input int kfix, input bit spur, input int hold, input int mode,
                          input int exp_lat, input int exp_mem0, input int exp_so, input string tag);
        int lat = -1;
        int n_mem0 = 0;
        int n_so = 0;
        build_trace(inst, kfix, spur, hold);
        @(negedge clk);
        applyStimulus(inst, 1'b1, 1'b0, spur | rbit());
        for (int i = 0; i < trace.size(); i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s step %0d", tag, i), 32'(obs[inst]), 32'(trace[i].obs));
            if (obs[inst][0] && lat < 0) lat = i + 1;
            if (obs[inst][3]) n_mem0++;
            if (obs[inst][2]) begin
                checkOutput($sformatf("%s store_out idx", tag), 32'(obs[inst][8:5]), 32'(n_so));
                n_so++;
            end
            if (mode == 1 && i == abort_idx) begin
                applyStimulus(inst, 1'b0, 1'b1, 1'b1);
                @(posedge clk);
                #1;
                checkOutput($sformatf("%s after abort", tag), 32'(obs[inst]), 32'd0);
                applyStimulus(inst, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (mode == 2 && i == ohash_idx) begin
                #2 reset_n = 1'b0;
                #1 checkOutput($sformatf("%s async reset", tag), 32'(obs[inst]), 32'd0);
                applyStimulus(inst, 1'b0, 1'b0, 1'b1);
                @(posedge clk);
                #1 checkOutput($sformatf("%s held reset", tag), 32'(obs[inst]), 32'd0);
                @(negedge clk);
                reset_n = 1'b1;
                @(posedge clk);
                #1 checkOutput($sformatf("%s after reset", tag), 32'(obs[inst]), 32'd0);
                applyStimulus(inst, 1'b0, 1'b0, 1'b0);
                return;
            end
            applyStimulus(inst, trace[i].init, 1'b0, trace[i].dv);
        end
        if (exp_lat > 0) checkOutput($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        checkOutput($sformatf("%s mem0 pulses", tag), 32'(n_mem0), 32'(exp_mem0));
        checkOutput($sformatf("%s store_out pulses", tag), 32'(n_so), 32'(exp_so));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t vecs[6];
        int   inst;
        vecs[0] = '{inst: 0, k: 1,  spur: 0, hold: 0, exp_lat: 10,  exp_mem0: 3, exp_so: 1};
        vecs[1] = '{inst: 1, k: 66, spur: 0, hold: 0, exp_lat: 806, exp_mem0: 8, exp_so: 4};
        vecs[2] = '{inst: 2, k: 1,  spur: 0, hold: 0, exp_lat: 6,   exp_mem0: 1, exp_so: 1};
        vecs[3] = '{inst: 0, k: 3,  spur: 1, hold: 5, exp_lat: 18,  exp_mem0: 3, exp_so: 1};
        vecs[4] = '{inst: 1, k: 2,  spur: 1, hold: 1, exp_lat: 38,  exp_mem0: 8, exp_so: 4};
        vecs[5] = '{inst: 2, k: 5,  spur: 0, hold: 2, exp_lat: 14,  exp_mem0: 1, exp_so: 1};

        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) checkOutput($sformatf("reset inst%0d", i), 32'(obs[i]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b0, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) checkOutput($sformatf("idle inst%0d", i), 32'(obs[i]), 32'd0);
        end
        for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b0, 1'b0);

        for (int v = 0; v < 6; v++)
            run_op(vecs[v].inst, vecs[v].k, vecs[v].spur, vecs[v].hold, 0,
                   vecs[v].exp_lat, vecs[v].exp_mem0, vecs[v].exp_so, $sformatf("vec%0d", v));

        run_op(1, 2, 0, 0, 1, -1, 0, 0, "abort");
        run_op(1, 2, 0, 0, 0, 38, 8, 4, "restart");
        run_op(0, 4, 0, 0, 2, -1, 0, 0, "resetmid");
        run_op(0, 1, 0, 0, 0, 10, 3, 1, "postreset");

        for (int r = 0; r < 6; r++) begin
            inst = $urandom_range(0, 2);
            run_op(inst, 0, 0, $urandom_range(0, 3), 0, -1,
                   niblk_t[inst] * nout_t[inst], nout_t[inst], $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
